// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/func
// constants, ALU operation codes, mux selector codes and ALUOp classes.
package mc_pkg;

    typedef enum logic [4:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RT_EX,
        S_RT_WB,
        S_IMM_EX,
        S_IMM_WB,
        S_BEQ,
        S_BNE,
        S_J,
        S_JAL,
        S_JR,
        S_HALT
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;

    localparam logic [5:0] FUNC_JR  = 6'b001000;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd2;
    localparam logic [1:0] PCSRC_A      = 2'd3;

    localparam logic [1:0] ALUOP_ADD  = 2'd0;
    localparam logic [1:0] ALUOP_SUB  = 2'd1;
    localparam logic [1:0] ALUOP_FUNC = 2'd2;
    localparam logic [1:0] ALUOP_SLT  = 2'd3;

    function automatic logic opc_legal(input logic [5:0] opc);
        case (opc)
            OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE,
            OPC_J, OPC_JAL, OPC_ADDI, OPC_SLTI: opc_legal = 1'b1;
            default:                            opc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_control.sv
// ALU decoder: turns the controller's ALUOp class plus the R-type func field
// into the 3-bit ALUOperation code.
module alu_control
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] func,
    output logic [2:0] alu_operation
);

    always_comb begin
        alu_operation = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_operation = ALU_ADD;
            ALUOP_SUB: alu_operation = ALU_SUB;
            ALUOP_SLT: alu_operation = ALU_SLT;
            default: begin
                case (func)
                    FUNC_ADD: alu_operation = ALU_ADD;
                    FUNC_SUB: alu_operation = ALU_SUB;
                    FUNC_AND: alu_operation = ALU_AND;
                    FUNC_OR:  alu_operation = ALU_OR;
                    FUNC_SLT: alu_operation = ALU_SLT;
                    default:  alu_operation = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath. Build option
// ILLEGAL_TRAP_EN: illegal opcodes halt with a sticky flag instead of acting as NOPs.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       PCLoad,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       JalSig1,
    output logic       MemToReg,
    output logic       JalSig2,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOperation,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       alu_used;
    logic [2:0] alu_decoded;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_START;
        else      state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_START:  next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OPC_RTYPE:         next_state = (func == FUNC_JR) ? S_JR : S_RT_EX;
                    OPC_LW, OPC_SW:    next_state = S_MEMADR;
                    OPC_BEQ:           next_state = S_BEQ;
                    OPC_BNE:           next_state = S_BNE;
                    OPC_J:             next_state = S_J;
                    OPC_JAL:           next_state = S_JAL;
                    OPC_ADDI, OPC_SLTI: next_state = S_IMM_EX;
`ifdef ILLEGAL_TRAP_EN
                    default:           next_state = S_HALT;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: next_state = (opc == OPC_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_RT_EX:  next_state = S_RT_WB;
            S_IMM_EX: next_state = S_IMM_WB;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Moore decode; zero only reaches PCLoad in the two branch states.
    always_comb begin
        PCLoad     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        JalSig1    = 1'b0;
        MemToReg   = 1'b0;
        JalSig2    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        PCSrc      = PCSRC_ALU;
        instr_done = 1'b0;
        alu_op     = ALUOP_ADD;
        alu_used   = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                alu_used = 1'b1;
                PCLoad   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB  = SRCB_IMM_SH;
                alu_used = 1'b1;
`ifndef ILLEGAL_TRAP_EN
                instr_done = !opc_legal(opc);
`endif
            end
            S_MEMADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                alu_used = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = 1'b1;
            end
            S_RT_EX: begin
                ALUSrcA  = 1'b1;
                alu_op   = ALUOP_FUNC;
                alu_used = 1'b1;
            end
            S_RT_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_IMM_EX: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                alu_op   = (opc == OPC_SLTI) ? ALUOP_SLT : ALUOP_ADD;
                alu_used = 1'b1;
            end
            S_IMM_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                alu_used   = 1'b1;
                PCSrc      = PCSRC_ALUOUT;
                PCLoad     = (state == S_BEQ) ? zero : !zero;
                instr_done = 1'b1;
            end
            S_J: begin
                PCSrc      = PCSRC_JUMP;
                PCLoad     = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                // $31 captures the already-incremented PC on the PC-update edge.
                PCSrc      = PCSRC_JUMP;
                PCLoad     = 1'b1;
                RegWrite   = 1'b1;
                JalSig1    = 1'b1;
                JalSig2    = 1'b1;
                instr_done = 1'b1;
            end
            S_JR: begin
                PCSrc      = PCSRC_A;
                PCLoad     = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    alu_control u_alu_control (
        .alu_op        (alu_op),
        .func          (func),
        .alu_operation (alu_decoded)
    );

    assign ALUOperation = alu_used ? alu_decoded : ALU_AND;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          illegal_q <= 1'b0;
        else if (state == S_DECODE && !opc_legal(opc))     illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: walks each instruction class
// through its state sequence and compares the full control word every cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opc = 6'b0;
    logic [5:0] func = 6'b0;
    logic       zero = 1'b0;
    logic       PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1;
    logic       MemToReg, JalSig2, RegWrite, ALUSrcA, instr_done, illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOperation;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
        .PCLoad(PCLoad), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .JalSig1(JalSig1), .MemToReg(MemToReg),
        .JalSig2(JalSig2), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOperation(ALUOperation), .PCSrc(PCSrc), .instr_done(instr_done), .illegal(illegal)
    );

    // Control word: PCLoad IorD MemRead MemWrite IRWrite RegDst JalSig1 MemToReg
    // JalSig2 RegWrite ALUSrcA ALUSrcB[2] ALUOperation[3] PCSrc[2] instr_done illegal
    logic [19:0] obs;
    assign obs = {PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg,
                  JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, instr_done, illegal};

    localparam logic [19:0] B_PCLOAD = 20'h80000, B_IORD = 20'h40000, B_MEMRD = 20'h20000;
    localparam logic [19:0] B_MEMWR = 20'h10000, B_IRW = 20'h08000, B_REGDST = 20'h04000;
    localparam logic [19:0] B_JAL1 = 20'h02000, B_M2R = 20'h01000, B_JAL2 = 20'h00800;
    localparam logic [19:0] B_REGW = 20'h00400, B_SRCA = 20'h00200;
    localparam logic [19:0] SB_FOUR = 20'h00080, SB_IMM = 20'h00100, SB_IMMSH = 20'h00180;
    localparam logic [19:0] OP_ADD = 20'h00020, OP_SUB = 20'h00060, OP_SLT = 20'h00070, OP_OR = 20'h00010;
    localparam logic [19:0] PC_JUMP = 20'h00004, PC_ALUOUT = 20'h00008, PC_A = 20'h0000C;
    localparam logic [19:0] B_DONE = 20'h00002, B_ILL = 20'h00001;

    localparam logic [19:0] E_FETCH  = B_PCLOAD | B_MEMRD | B_IRW | SB_FOUR | OP_ADD;
    localparam logic [19:0] E_DECODE = SB_IMMSH | OP_ADD;
    localparam logic [19:0] E_MEMADR = B_SRCA | SB_IMM | OP_ADD;
    localparam logic [19:0] E_MEMRD  = B_MEMRD | B_IORD;
    localparam logic [19:0] E_MEMWB  = B_REGW | B_M2R | B_DONE;
    localparam logic [19:0] E_MEMWR  = B_MEMWR | B_IORD | B_DONE;
    localparam logic [19:0] E_RT_WB  = B_REGW | B_REGDST | B_DONE;
    localparam logic [19:0] E_IMM_WB = B_REGW | B_DONE;
    localparam logic [19:0] E_BR_NT  = B_SRCA | OP_SUB | PC_ALUOUT | B_DONE;
    localparam logic [19:0] E_BR_T   = E_BR_NT | B_PCLOAD;
    localparam logic [19:0] E_J      = B_PCLOAD | PC_JUMP | B_DONE;
    localparam logic [19:0] E_JAL    = E_J | B_REGW | B_JAL1 | B_JAL2;
    localparam logic [19:0] E_JR     = B_PCLOAD | PC_A | B_DONE;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, 20'h0); end
        step();
        step();
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, 20'h0); end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL start_state: got %h expected %h", obs, 20'h0); end
        step();
        checks++;
        if (obs !== E_FETCH) begin errors++; $display("FAIL first_fetch: got %h expected %h", obs, E_FETCH); end
    endtask

    task automatic test_lw();
        logic [19:0] seq[$];
        seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        opc = 6'b100011;
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (obs !== seq[i]) begin errors++; $display("FAIL lw_state%0d: got %h expected %h", i, obs, seq[i]); end
            step();
        end
    endtask

    task automatic test_sw();
        logic [19:0] seq[$];
        seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        opc = 6'b101011;
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (obs !== seq[i]) begin errors++; $display("FAIL sw_state%0d: got %h expected %h", i, obs, seq[i]); end
            step();
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  funcs[$];
        logic [19:0] ex_ops[$];
        logic [19:0] seq[$];
        funcs  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000, 6'b111111};
        ex_ops = '{OP_SUB, 20'h0, OP_OR, OP_SLT, OP_ADD, OP_ADD};
        opc = 6'b000000;
        for (int k = 0; k < funcs.size(); k++) begin
            func = funcs[k];
            seq = '{E_FETCH, E_DECODE, B_SRCA | ex_ops[k], E_RT_WB};
            for (int i = 0; i < seq.size(); i++) begin
                checks++;
                if (obs !== seq[i])
                    begin errors++; $display("FAIL rtype_f%b_state%0d: got %h expected %h", func, i, obs, seq[i]); end
                step();
            end
        end
    endtask

    task automatic test_imm();
        logic [19:0] seq[$];
        opc = 6'b001000;
        seq = '{E_FETCH, E_DECODE, E_MEMADR, E_IMM_WB};
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (obs !== seq[i]) begin errors++; $display("FAIL addi_state%0d: got %h expected %h", i, obs, seq[i]); end
            step();
        end
        opc = 6'b001010;
        seq = '{E_FETCH, E_DECODE, B_SRCA | SB_IMM | OP_SLT, E_IMM_WB};
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (obs !== seq[i]) begin errors++; $display("FAIL slti_state%0d: got %h expected %h", i, obs, seq[i]); end
            step();
        end
    endtask

    task automatic test_branch();
        for (int b = 0; b < 2; b++) begin
            opc = (b == 0) ? 6'b000100 : 6'b000101;
            checks++;
            if (obs !== E_FETCH) begin errors++; $display("FAIL br%0d_fetch: got %h expected %h", b, obs, E_FETCH); end
            step();
            checks++;
            if (obs !== E_DECODE) begin errors++; $display("FAIL br%0d_decode: got %h expected %h", b, obs, E_DECODE); end
            step();
            zero = 1'b1;
            #1;
            checks++;
            if (obs !== ((b == 0) ? E_BR_T : E_BR_NT))
                begin errors++; $display("FAIL br%0d_zero1: got %h expected %h", b, obs, (b == 0) ? E_BR_T : E_BR_NT); end
            zero = 1'b0;
            #1;
            checks++;
            if (obs !== ((b == 0) ? E_BR_NT : E_BR_T))
                begin errors++; $display("FAIL br%0d_zero0: got %h expected %h", b, obs, (b == 0) ? E_BR_NT : E_BR_T); end
            step();
        end
    endtask

    task automatic test_jumps();
        logic [5:0]  opcs[$];
        logic [19:0] last[$];
        opcs = '{6'b000010, 6'b000011, 6'b000000};
        last = '{E_J, E_JAL, E_JR};
        func = 6'b001000;
        zero = 1'b1;
        for (int k = 0; k < opcs.size(); k++) begin
            opc = opcs[k];
            checks++;
            if (obs !== E_FETCH) begin errors++; $display("FAIL jump%0d_fetch: got %h expected %h", k, obs, E_FETCH); end
            step();
            checks++;
            if (obs !== E_DECODE) begin errors++; $display("FAIL jump%0d_decode: got %h expected %h", k, obs, E_DECODE); end
            step();
            checks++;
            if (obs !== last[k]) begin errors++; $display("FAIL jump%0d_exec: got %h expected %h", k, obs, last[k]); end
            step();
        end
        zero = 1'b0;
    endtask

    task automatic test_reset_mid();
        opc = 6'b100011;
        step();
        step();
        step();
        checks++;
        if (obs !== E_MEMRD) begin errors++; $display("FAIL mid_memrd: got %h expected %h", obs, E_MEMRD); end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL mid_reset: got %h expected %h", obs, 20'h0); end
        step();
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL mid_reset_held: got %h expected %h", obs, 20'h0); end
        rst = 1'b1;
        step();
        checks++;
        if (obs !== E_FETCH) begin errors++; $display("FAIL mid_refetch: got %h expected %h", obs, E_FETCH); end
    endtask

    task automatic test_illegal();
        opc = 6'b111111;
        checks++;
        if (obs !== E_FETCH) begin errors++; $display("FAIL ill_fetch: got %h expected %h", obs, E_FETCH); end
        step();
`ifdef ILLEGAL_TRAP_EN
        checks++;
        if (obs !== E_DECODE) begin errors++; $display("FAIL ill_decode: got %h expected %h", obs, E_DECODE); end
        step();
        opc = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== B_ILL) begin errors++; $display("FAIL ill_halt%0d: got %h expected %h", i, obs, B_ILL); end
            step();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL ill_reset: got %h expected %h", obs, 20'h0); end
        step();
        rst = 1'b1;
        step();
`else
        checks++;
        if (obs !== (E_DECODE | B_DONE))
            begin errors++; $display("FAIL ill_nop_decode: got %h expected %h", obs, E_DECODE | B_DONE); end
        step();
`endif
        checks++;
        if (obs !== E_FETCH) begin errors++; $display("FAIL ill_after: got %h expected %h", obs, E_FETCH); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_imm();
        test_branch();
        test_jumps();
        test_reset_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the multi-cycle MIPS datapath.
- Inputs: opcode, function field and ALU zero flag, all from the datapath.
- Outputs: every datapath control line for each phase of each instruction (PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg, JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc).
- Sits beside the datapath in the CPU top level.

Parameters:
- none; all encodings are fixed in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- opc  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag (combinational, same cycle)
- PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg, JalSig2, RegWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  0=B, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2
- ALUOperation  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  0=ALU result, 1=jump target, 2=ALUOut, 3=A
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  see Optional Feature

Behaviour:
- Reset (rst=0, asynchronous): state=START. In START all outputs are 0, including ALUSrcB/PCSrc=00 and ALUOperation=000. START always goes to FETCH on the next edge.
- Outputs are purely a function of state, plus zero in the branch states. Any control not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, add, PCSrc=0, PCLoad=1. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, add (ALUOut <= branch target). Dispatch on opc:
  - 000000 R-type: func 001000 -> JR; otherwise -> RT_EX
  - 100011 lw, 101011 sw -> MEMADR
  - 000100 -> BEQ; 000101 -> BNE
  - 000010 -> J; 000011 -> JAL
  - 001000 addi, 001010 slti -> IMM_EX
  - anything else -> ILLEGAL handling
- MEMADR: ALUSrcA=1, ALUSrcB=2, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1 -> MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0, instr_done=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1, instr_done=1 -> FETCH.
- RT_EX: ALUSrcA=1, ALUSrcB=0; ALUOperation from func via alu_control (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other func -> add). Next: RT_WB.
- RT_WB: RegWrite=1, RegDst=1, MemToReg=0, instr_done=1 -> FETCH.
- IMM_EX: ALUSrcA=1, ALUSrcB=2; add for addi, slt for slti -> IMM_WB.
- IMM_WB: RegWrite=1, RegDst=0, MemToReg=0, instr_done=1 -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=0, sub, PCSrc=2, PCLoad=zero, instr_done=1 -> FETCH.
- BNE: same as BEQ but PCLoad=~zero.
- J: PCSrc=1, PCLoad=1, instr_done=1 -> FETCH.
- JAL: PCSrc=1, PCLoad=1, RegWrite=1, JalSig1=1, JalSig2=1, instr_done=1 -> FETCH. $31 receives the old PC (already PC+4) on the same edge the PC updates.
- JR: PCSrc=3, PCLoad=1, instr_done=1 -> FETCH.
- Latency in cycles, FETCH to last state inclusive: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3.
- Reset asserted mid-instruction: state returns to START immediately; no partial write occurs after reset is asserted.
- The state register is the only sequential element, besides the illegal flag when enabled.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to HALT. In HALT all controls are 0 and illegal=1 (sticky); only reset exits HALT.
- Undefined: an illegal opcode is treated as a NOP. DECODE goes to FETCH with instr_done=1 in that cycle. illegal is tied to 0.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - opcode and func constants
  - ALUOperation codes
  - ALUSrcB and PCSrc selector codes
  - 2-bit ALUOp class codes: add, sub, func-driven, slt
- Sub-module alu_control: combinational; maps (ALUOp class, func) -> ALUOperation. Instantiated once.

Test Plan:
- Assert rst=0 mid-state, then release: outputs all 0 in START. Next cycle FETCH: MemRead=1, IRWrite=1, PCLoad=1, ALUSrcB=01, ALUOperation=010.
- opc=100011 (lw): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMWB has RegWrite=1, MemToReg=1, RegDst=0, instr_done=1.
- opc=000000, func=100010 (sub): RT_EX has ALUOperation=110, ALUSrcA=1, ALUSrcB=00. RT_WB has RegDst=1, RegWrite=1.
- opc=000100 (beq): zero=1 gives PCLoad=1, PCSrc=10; zero=0 gives PCLoad=0. Repeat with opc=000101 (bne): results inverted.
- opc=000011 (jal): one state with JalSig1=1, JalSig2=1, RegWrite=1, PCLoad=1, PCSrc=01. Then opc=000000, func=001000 (jr): PCSrc=11, PCLoad=1.
- opc=111111 (illegal): with ILLEGAL_TRAP_EN, illegal=1 and all controls stay 0 until reset. Without it, next state is FETCH and illegal=0.
